// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Brief    : Shared widths, op encodings, FSM state encoding and result helpers
//            for calculator_core.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int OPW  = 16;
    localparam int RESW = 32;
    localparam int ITER = 16;
    localparam int CNTW = 5;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_MUL = 2'b10;
    localparam logic [1:0] c_OP_DIV = 2'b11;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    function automatic logic [RESW-1:0] add_zext(input logic [OPW-1:0] a,
                                                 input logic [OPW-1:0] b);
        logic [OPW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {{(RESW-OPW-1){1'b0}}, s};
    endfunction

    // Bit OPW of the 17-bit difference is the borrow, i.e. the sign.
    function automatic logic [RESW-1:0] sub_sext(input logic [OPW-1:0] a,
                                                 input logic [OPW-1:0] b);
        logic [OPW:0] d;
        d = {1'b0, a} - {1'b0, b};
        return {{(RESW-OPW-1){d[OPW]}}, d};
    endfunction

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : calc_muldiv_seq
// Brief    : Iterative shift-add multiplier and (with CALC_DIV_EN) restoring
//            divider, one bit per cycle over ITER cycles.
// Revision : 1.0 - initial release
// ============================================================================
module calc_muldiv_seq
    import calc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    input  logic [OPW-1:0]  op_a,
    input  logic [OPW-1:0]  op_b,
    output logic [CNTW-1:0] count,
    output logic [RESW-1:0] result,
    output logic            last
);

    logic            r_run;
    logic [CNTW-1:0] r_count;
    logic [RESW-1:0] r_acc;
    logic [RESW-1:0] r_mcand;
    logic [OPW-1:0]  r_mplier;
    logic [RESW-1:0] w_acc_next;
    logic            w_go;

    // result is the value after the step taken at the coming edge, so the
    // owner can capture it on the same edge that last is high.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign last       = r_run && (r_count == CNTW'(ITER - 1));
    assign count      = r_count;

`ifdef CALC_DIV_EN
    logic           r_mode;
    logic [OPW-1:0] r_rem;
    logic [OPW-1:0] r_quo;
    logic [OPW-1:0] r_div;
    logic [OPW:0]   w_shift;
    logic [OPW+1:0] w_diff;
    logic           w_fit;
    logic [OPW-1:0] w_rem_next;
    logic [OPW-1:0] w_quo_next;
    logic           w_unused_diff;

    assign w_go          = start;
    assign w_shift       = {r_rem, r_quo[OPW-1]};
    assign w_diff        = {1'b0, w_shift} - {2'b00, r_div};
    assign w_fit         = ~w_diff[OPW+1];
    assign w_rem_next    = w_fit ? w_diff[OPW-1:0] : w_shift[OPW-1:0];
    assign w_quo_next    = {r_quo[OPW-2:0], w_fit};
    assign w_unused_diff = w_diff[OPW];
    assign result        = r_mode ? {w_rem_next, w_quo_next} : w_acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= 1'b0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
        end else if (w_go) begin
            r_mode <= mode;
            r_rem  <= '0;
            r_quo  <= op_a;
            r_div  <= op_b;
        end else if (r_run) begin
            r_rem  <= w_rem_next;
            r_quo  <= w_quo_next;
        end
    end
`else
    assign w_go   = start & ~mode;
    assign result = w_acc_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run    <= 1'b0;
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (w_go) begin
            r_run    <= 1'b1;
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= {{(RESW-OPW){1'b0}}, op_a};
            r_mplier <= op_b;
        end else if (r_run) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (last) begin
                r_run   <= 1'b0;
                r_count <= '0;
            end else begin
                r_count <= r_count + CNTW'(1);
            end
        end
    end

endmodule : calc_muldiv_seq
`default_nettype wire

// File: rtl/calculator_core.sv
`default_nettype none
// ============================================================================
// Module   : calculator_core
// Brief    : 16-bit add/sub/mul/div calculator with registered 32-bit result.
//            Divider built only when CALC_DIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module calculator_core
    import calc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [OPW-1:0]  op_a,
    input  logic [OPW-1:0]  op_b,
    output logic [RESW-1:0] cal_result,
    output logic            done,
    output logic            busy,
    output logic            err
);

    logic [1:0]      r_state;
    logic [1:0]      r_op;
    logic [OPW-1:0]  r_a;
    logic [OPW-1:0]  r_b;
    logic            w_md_start;
    logic            w_md_last;
    logic [RESW-1:0] w_md_result;
    logic [CNTW-1:0] w_unused_md_count;

    // Operands go to the sequencer straight from the ports on the accept edge.
    assign w_md_start = (r_state == c_ST_IDLE) && start && op[1];

    calc_muldiv_seq u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (w_md_start),
        .mode   (op[0]),
        .op_a   (op_a),
        .op_b   (op_b),
        .count  (w_unused_md_count),
        .result (w_md_result),
        .last   (w_md_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_op       <= c_OP_ADD;
            r_a        <= '0;
            r_b        <= '0;
            cal_result <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_a     <= op_a;
                        r_b     <= op_b;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= c_ST_CALC;
                    end
                end
                c_ST_CALC: begin
                    case (r_op)
                        c_OP_ADD: begin
                            cal_result <= add_zext(r_a, r_b);
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            r_state    <= c_ST_DONE;
                        end
                        c_OP_SUB: begin
                            cal_result <= sub_sext(r_a, r_b);
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            r_state    <= c_ST_DONE;
                        end
                        c_OP_MUL: begin
                            if (w_md_last) begin
                                cal_result <= w_md_result;
                                done       <= 1'b1;
                                busy       <= 1'b0;
                                r_state    <= c_ST_DONE;
                            end
                        end
                        default: begin
`ifdef CALC_DIV_EN
                            if (w_md_last) begin
                                cal_result <= (r_b == '0) ? '1 : w_md_result;
                                err        <= (r_b == '0);
                                done       <= 1'b1;
                                busy       <= 1'b0;
                                r_state    <= c_ST_DONE;
                            end
`else
                            cal_result <= '0;
                            err        <= 1'b1;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            r_state    <= c_ST_DONE;
`endif
                        end
                    endcase
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule : calculator_core
`default_nettype wire

// File: tb/tb_calculator_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_calculator_core
// Brief    : Self-checking bench for calculator_core (default or CALC_DIV_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_calculator_core;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [31:0] cal_result;
    logic        done;
    logic        busy;
    logic        err;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] res;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          lat;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    exp_t sb_q[$];
    vec_t vecs[12];

    calculator_core dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .op_a       (op_a),
        .op_b       (op_b),
        .cal_result (cal_result),
        .done       (done),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one start pulse; returns at the first negedge after the accept edge
    // with the operand inputs scrambled to prove they are not re-sampled.
    task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        op = o; op_a = a; op_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        op_a  = 16'($urandom);
        op_b  = 16'($urandom);
    endtask

    task automatic wait_done(input int n0, output int lat, output bit ok);
        int n;
        n  = n0;
        ok = 1'b0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        lat = n - 1;
    endtask

    task automatic score(input string name, input int n0);
        int   lat;
        bit   ok;
        exp_t e;
        wait_done(n0, lat, ok);
        e = sb_q.pop_front();
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no done within 40 cycles, expected latency %0d", name, e.lat);
        end else begin
            check({name, " result"}, cal_result, e.res);
            check({name, " err"}, 32'(err), 32'(e.err));
            check({name, " latency"}, 32'(lat), 32'(e.lat));
            check({name, " busy at done"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        sb_q.push_back('{v.res, v.err, v.lat});
        issue(v.op, v.a, v.b);
        check($sformatf("vec%0d busy after accept", i), 32'(busy), 32'd1);
        score($sformatf("vec%0d", i), 1);
        @(negedge clk);
        check($sformatf("vec%0d done single cycle", i), 32'(done), 32'd0);
    endtask

    initial begin
        int dc;
        rst = 1'b1; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        check("reset cal_result", cal_result, 32'h0);
        check("reset done", 32'(done), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset err", 32'(err), 32'd0);
        rst = 1'b0;

        vecs[0]  = '{c_OP_ADD, 16'hFFFF, 16'h0001, 32'h0001_0000, 1'b0, 1};
        vecs[1]  = '{c_OP_SUB, 16'h0003, 16'h0005, 32'hFFFF_FFFE, 1'b0, 1};
        vecs[2]  = '{c_OP_MUL, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 16};
`ifdef CALC_DIV_EN
        vecs[3]  = '{c_OP_DIV, 16'd100,  16'd7,    32'h0002_000E, 1'b0, 16};
        vecs[4]  = '{c_OP_DIV, 16'h1234, 16'h0000, 32'hFFFF_FFFF, 1'b1, 16};
        vecs[9]  = '{c_OP_DIV, 16'hFFFF, 16'h0001, 32'h0000_FFFF, 1'b0, 16};
        vecs[10] = '{c_OP_DIV, 16'h0007, 16'h0064, 32'h0007_0000, 1'b0, 16};
`else
        vecs[3]  = '{c_OP_DIV, 16'd100,  16'd7,    32'h0, 1'b1, 1};
        vecs[4]  = '{c_OP_DIV, 16'h1234, 16'h0000, 32'h0, 1'b1, 1};
        vecs[9]  = '{c_OP_DIV, 16'hFFFF, 16'h0001, 32'h0, 1'b1, 1};
        vecs[10] = '{c_OP_DIV, 16'h0007, 16'h0064, 32'h0, 1'b1, 1};
`endif
        vecs[5]  = '{c_OP_ADD, 16'h1234, 16'h4321, 32'h0000_5555, 1'b0, 1};
        vecs[6]  = '{c_OP_SUB, 16'h0000, 16'h0001, 32'hFFFF_FFFF, 1'b0, 1};
        vecs[7]  = '{c_OP_MUL, 16'h1234, 16'h0010, 32'h0001_2340, 1'b0, 16};
        vecs[8]  = '{c_OP_MUL, 16'h0000, 16'hBEEF, 32'h0000_0000, 1'b0, 16};
        vecs[11] = '{c_OP_SUB, 16'hFFFF, 16'h0000, 32'h0000_FFFF, 1'b0, 1};

        for (int i = 0; i < 12; i++) run_vec(i);

        // Result holds while idle inputs wander.
        repeat (6) begin
            @(negedge clk);
            op = 2'($urandom); op_a = 16'($urandom); op_b = 16'($urandom);
        end
        check("hold cal_result", cal_result, 32'h0000_FFFF);

        // Start raised while in DONE is dropped.
        sb_q.push_back('{32'h0000_0003, 1'b0, 1});
        issue(c_OP_ADD, 16'd1, 16'd2);
        score("done-state add", 1);
        #1 dc = done_cnt;
        start = 1'b1; op = c_OP_ADD; op_a = 16'd5; op_b = 16'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("done-state start busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        #1;
        check("done-state start no done", 32'(done_cnt - dc), 32'd0);
        check("done-state start result", cal_result, 32'h0000_0003);

        // Start pulsed mid-multiply is not queued.
        sb_q.push_back('{32'h0000_FFFF, 1'b0, 16});
        issue(c_OP_MUL, 16'h00FF, 16'h0101);
        #1 dc = done_cnt;
        repeat (3) @(negedge clk);
        start = 1'b1; op = c_OP_ADD; op_a = 16'd1; op_b = 16'd1;
        @(negedge clk);
        start = 1'b0;
        score("mul with stray start", 5);
        repeat (20) @(negedge clk);
        #1;
        check("mul stray start single done", 32'(done_cnt - dc), 32'd1);
        check("mul stray start idle", 32'(busy), 32'd0);

        // Reset in the middle of an iterative op aborts it.
`ifdef CALC_DIV_EN
        issue(c_OP_DIV, 16'd100, 16'd7);
`else
        issue(c_OP_MUL, 16'd100, 16'd7);
`endif
        #1 dc = done_cnt;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort cal_result", cal_result, 32'h0);
        check("abort done", 32'(done), 32'd0);
        repeat (20) @(negedge clk);
        #1;
        check("abort no done pulse", 32'(done_cnt - dc), 32'd0);
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        run_vec(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_calculator_core
`default_nettype wire
